// File: rtl/store_buffer_pkg.sv
// Shared constants and entry layout for the posted-write store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = 2;

    // Clears the byte offset so the RAM always sees a word-aligned address.
    localparam logic [31:0] SB_WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_lane_merge.sv
// Byte-lane merge of a new store into an existing buffered word.
module sb_lane_merge (
    input  logic [3:0]  old_byteen_i,
    input  logic [31:0] old_wdata_i,
    input  logic [3:0]  new_byteen_i,
    input  logic [31:0] new_wdata_i,
    output logic [3:0]  merged_byteen_o,
    output logic [31:0] merged_wdata_o
);

    // Newly enabled lanes overwrite the old bytes; other lanes keep their data.
    always_comb begin
        merged_byteen_o = old_byteen_i | new_byteen_i;
        merged_wdata_o  = old_wdata_i;
        for (int i = 0; i < 4; i++) begin
            if (new_byteen_i[i]) begin
                merged_wdata_o[8*i +: 8] = new_wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues aligned stores, merges back-to-back
// stores to the same word, drains to the data RAM and flags load hazards.
//
// Bus handshake: bus_valid is high whenever an entry is pending and the bus_*
// payload is the head entry, held stable until the cycle bus_valid && bus_ready
// are both high; that cycle the head retires. The store side has no valid bit:
// a nonzero in_byteen is the request, and it is taken only when in_ready is high.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_addr,
    input  logic [3:0]  in_byteen,
    input  logic [31:0] in_wdata,
    output logic        in_ready,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        empty
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    sb_entry_t        entry_q [DEPTH];
    sb_entry_t        entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [PTR_W-1:0] tail_m1;
    logic             store_req, do_merge, do_enq, do_deq;
    logic [3:0]       merged_byteen;
    logic [31:0]      merged_wdata;
    logic             ld_hit;

    // Byte offsets are irrelevant: both the bus and hazard compare work on words.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{in_addr[1:0], ld_addr[1:0]};

    assign tail_m1   = tail_q - PTR_ONE;
    assign in_ready  = (count_q != FULL_CNT);
    assign bus_valid = (count_q != '0);
    assign empty     = (count_q == '0);
    assign do_deq    = bus_valid && bus_ready;
    assign store_req = (in_byteen != 4'b0000) && in_ready;

    // A store coalesces into the newest entry unless that entry is the only one and is leaving now.
    assign do_merge = store_req && (count_q != '0)
                   && (entry_q[tail_m1].waddr == in_addr[31:2])
                   && !((count_q == CNT_ONE) && do_deq);
    assign do_enq   = store_req && !do_merge;

    sb_lane_merge u_lane_merge (
        .old_byteen_i    (entry_q[tail_m1].byteen),
        .old_wdata_i     (entry_q[tail_m1].wdata),
        .new_byteen_i    (in_byteen),
        .new_wdata_i     (in_wdata),
        .merged_byteen_o (merged_byteen),
        .merged_wdata_o  (merged_wdata)
    );

    // Head payload is gated so an empty buffer presents an all-zero bus.
    always_comb begin
        bus_addr   = '0;
        bus_byteen = '0;
        bus_wdata  = '0;
        if (bus_valid) begin
            bus_addr   = {entry_q[head_q].waddr, 2'b00} & SB_WORD_MASK;
            bus_byteen = entry_q[head_q].byteen;
            bus_wdata  = entry_q[head_q].wdata;
        end
    end

    // Any pending word matching the load word is a hazard, including the retiring head.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].waddr == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
        ld_hazard = ld_check && ld_hit;
    end

    // Next-state for entries, pointers and occupancy.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_merge) begin
            entry_d[tail_m1].byteen = merged_byteen;
            entry_d[tail_m1].wdata  = merged_wdata;
        end
        if (do_enq) begin
            entry_d[tail_q].waddr  = in_addr[31:2];
            entry_d[tail_q].byteen = in_byteen;
            entry_d[tail_q].wdata  = in_wdata;
            valid_d[tail_q]        = 1'b1;
            tail_d                 = tail_q + PTR_ONE;
        end
        if (do_deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the buffer.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_addr;
    logic [3:0]  in_byteen;
    logic [31:0] in_wdata;
    logic        in_ready;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        empty;

    int vectors     = 0;
    int miscompares = 0;

    // Model: pending words in drain order.
    logic [29:0] exp_addr_q[$];
    logic [3:0]  exp_be_q[$];
    logic [31:0] exp_wd_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_addr    (in_addr),
        .in_byteen  (in_byteen),
        .in_wdata   (in_wdata),
        .in_ready   (in_ready),
        .bus_valid  (bus_valid),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .ld_check   (ld_check),
        .ld_addr    (ld_addr),
        .ld_hazard  (ld_hazard),
        .empty      (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every output with the model's view of the queue.
    task automatic check_outputs();
        int  sz;
        logic hit;
        sz  = exp_addr_q.size();
        hit = 1'b0;
        foreach (exp_addr_q[i]) if (exp_addr_q[i] == ld_addr[31:2]) hit = 1'b1;
        chk("in_ready",  {31'd0, in_ready},  {31'd0, sz != DEPTH});
        chk("bus_valid", {31'd0, bus_valid}, {31'd0, sz != 0});
        chk("empty",     {31'd0, empty},     {31'd0, sz == 0});
        chk("ld_hazard", {31'd0, ld_hazard}, {31'd0, ld_check && hit});
        if (sz != 0) begin
            chk("bus_addr",   bus_addr,           {exp_addr_q[0], 2'b00});
            chk("bus_byteen", {28'd0, bus_byteen}, {28'd0, exp_be_q[0]});
            chk("bus_wdata",  bus_wdata,          exp_wd_q[0]);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, pass the edge.
    task automatic step();
        int   sz;
        logic ret;
        logic [3:0]  b;
        logic [31:0] w;
        @(negedge clk);
        check_outputs();
        if (reset_n) begin
            sz  = exp_addr_q.size();
            ret = (sz != 0) && bus_ready;
            if (in_byteen != 4'b0000 && sz != DEPTH) begin
                if (sz != 0 && exp_addr_q[sz-1] == in_addr[31:2] && !(sz == 1 && ret)) begin
                    b = exp_be_q[sz-1];
                    w = exp_wd_q[sz-1];
                    for (int i = 0; i < 4; i++) if (in_byteen[i]) w[8*i +: 8] = in_wdata[8*i +: 8];
                    exp_be_q[sz-1] = b | in_byteen;
                    exp_wd_q[sz-1] = w;
                end else begin
                    exp_addr_q.push_back(in_addr[31:2]);
                    exp_be_q.push_back(in_byteen);
                    exp_wd_q.push_back(in_wdata);
                end
            end
            if (ret) begin
                void'(exp_addr_q.pop_front());
                void'(exp_be_q.pop_front());
                void'(exp_wd_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        in_addr = a; in_byteen = be; in_wdata = wd;
        step();
        in_byteen = 4'b0000;
    endtask

    task automatic idle(input int n);
        in_byteen = 4'b0000;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_n = 1'b0; in_addr = '0; in_byteen = '0; in_wdata = '0;
        bus_ready = 1'b0; ld_check = 1'b0; ld_addr = '0;
        #12;
        // Reset values
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_bus_addr",  bus_addr,           32'd0);
        chk("rst_byteen",    {28'd0, bus_byteen}, 32'd0);
        chk("rst_wdata",     bus_wdata,          32'd0);
        chk("rst_empty",     {31'd0, empty},     32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single store, drained immediately
        bus_ready = 1'b1;
        store(32'h100, 4'b0001, 32'h0000_00AB);
        chk("s1_valid",  {31'd0, bus_valid}, 32'd1);
        chk("s1_addr",   bus_addr,           32'h100);
        chk("s1_byteen", {28'd0, bus_byteen}, 32'h1);
        chk("s1_wdata",  bus_wdata,          32'h0000_00AB);
        idle(1);
        chk("s1_empty",  {31'd0, empty},     32'd1);

        // Two halfword stores to one word merge
        bus_ready = 1'b0;
        store(32'h200, 4'b0011, 32'h0000_1234);
        store(32'h202, 4'b1100, 32'h5678_0000);
        chk("mg_byteen", {28'd0, bus_byteen}, 32'hF);
        chk("mg_wdata",  bus_wdata,          32'h5678_1234);
        chk("mg_count",  exp_addr_q.size(),  32'd1);
        bus_ready = 1'b1;
        idle(2);

        // Fill to capacity, reject a fifth store, then drain in order
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'(i * 4), 4'b1111, $urandom);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        store(32'h10, 4'b1111, 32'hDEAD_BEEF);
        bus_ready = 1'b1;
        idle(1);
        chk("drain1_ready", {31'd0, in_ready}, 32'd1);
        chk("drain1_addr",  bus_addr,          32'h4);
        idle(4);

        // Load hazard against a pending word
        bus_ready = 1'b0;
        store(32'h300, 4'b0001, 32'h11);
        ld_check = 1'b1; ld_addr = 32'h302; #1;
        chk("hz_hit",  {31'd0, ld_hazard}, 32'd1);
        ld_addr = 32'h304; #1;
        chk("hz_miss", {31'd0, ld_hazard}, 32'd0);
        idle(1);
        ld_check = 1'b0;
        bus_ready = 1'b1;
        idle(2);

        // Store to the retiring sole entry becomes a new entry
        bus_ready = 1'b0;
        store(32'h40, 4'b0001, 32'h0000_0001);
        bus_ready = 1'b1;
        store(32'h40, 4'b0010, 32'h0000_0200);
        chk("nomerge_addr",   bus_addr,            32'h40);
        chk("nomerge_byteen", {28'd0, bus_byteen}, 32'h2);
        idle(2);

        // Asynchronous reset with three entries pending
        bus_ready = 1'b0;
        store(32'h500, 4'b0001, 32'h1);
        store(32'h504, 4'b0001, 32'h2);
        store(32'h508, 4'b0001, 32'h3);
        ld_check = 1'b1; ld_addr = 32'h504;
        reset_n = 1'b0; #1;
        chk("ar_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("ar_empty",     {31'd0, empty},     32'd1);
        chk("ar_in_ready",  {31'd0, in_ready},  32'd1);
        chk("ar_hazard",    {31'd0, ld_hazard}, 32'd0);
        exp_addr_q.delete(); exp_be_q.delete(); exp_wd_q.delete();
        idle(1);
        reset_n = 1'b1;
        ld_check = 1'b0;

        // Random traffic over a small address window to provoke merges and hazards
        for (int n = 0; n < 400; n++) begin
            in_addr   = {26'd0, 4'($urandom_range(0, 7)), 2'($urandom)};
            in_byteen = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            in_wdata  = $urandom;
            bus_ready = ($urandom_range(0, 2) != 0);
            ld_check  = 1'($urandom);
            ld_addr   = {26'd0, 4'($urandom_range(0, 7)), 2'($urandom)};
            step();
        end
        in_byteen = 4'b0000;
        bus_ready = 1'b1;
        idle(6);
        chk("final_empty", {31'd0, empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the memory-stage byte-enable/data-alignment logic and the external data-RAM bus.
- Accepts aligned store requests (word address, 4-bit byte enable, lane-positioned write data) and queues them in a small FIFO.
- Drains entries to the RAM through a valid/ready handshake, merging consecutive stores to the same word into one entry.
- Flags loads that hit a pending word so hazard control can stall the load until the buffer drains.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_addr  input  32  store byte address from the memory stage; bits [1:0] are ignored.
- in_byteen  input  4  byte-lane enables; 4'b0000 means no store this cycle.
- in_wdata  input  32  lane-positioned write data.
- in_ready  output  1  buffer can accept a store this cycle.
- bus_valid  output  1  head entry is presented to the RAM.
- bus_addr  output  32  head word address, {addr[31:2], 2'b00}.
- bus_byteen  output  4  head byte enables.
- bus_wdata  output  32  head write data.
- bus_ready  input  1  RAM accepts the head this cycle.
- ld_check  input  1  a load is in the memory stage.
- ld_addr  input  32  load byte address.
- ld_hazard  output  1  the load word matches a pending entry.
- empty  output  1  count == 0.

Behaviour:
- Reset (asynchronous, reset_n low):
  - head = 0, tail = 0, count = 0, all entry valid bits cleared.
  - Outputs: in_ready = 1, bus_valid = 0, bus_addr/bus_byteen/bus_wdata = 0, ld_hazard = 0, empty = 1.
- Storage: DEPTH entries, each holding a word address [31:2], byteen[3:0] and wdata[31:0]. Count width is PTR_W+1.
- in_ready = (count != DEPTH). It is computed from registered count only, so there is no same-cycle pass-through when full.
- Store request: in_byteen != 0 && in_ready. Requests with byteen == 0 are discarded and leave no state change.
- Merge condition, all true:
  - count != 0;
  - the tail-1 entry's word address equals in_addr[31:2];
  - NOT (count == 1 && bus_valid && bus_ready), i.e. the entry being merged is not retiring this cycle.
- On merge:
  - entry byteen |= in_byteen;
  - for each lane i with in_byteen[i] set, wdata byte i takes the new byte;
  - count and tail are unchanged.
- Otherwise the request is enqueued at tail: tail++ (wraps modulo DEPTH) and count++.
- Drain: bus_valid = (count != 0). bus_* is driven combinationally from the head entry.
  - On bus_valid && bus_ready: head++ (wraps) and count--.
  - bus_* stays stable while bus_valid && !bus_ready.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When full, enqueue is blocked even if a dequeue occurs that cycle.
- Merge and dequeue in the same cycle is legal whenever count >= 2, since the merge targets the tail and the dequeue retires the head.
- ld_hazard (combinational) = ld_check && some valid entry has word address == ld_addr[31:2]. An entry retiring this cycle still counts.
- Byte enables are never zero inside the FIFO.
- Throughput: one enqueue (or merge) per cycle and one drain per cycle.
- Latency: a store into an empty buffer appears on bus_valid the next cycle.
- Reset asserted mid-operation drops all pending entries; no partial bus transaction is held.

Decomposition:
- Shared constants go in the common def header: SB_DEPTH, and the bus word-align mask.
- One natural combinational sub-module, sb_lane_merge: inputs old byteen/wdata and new byteen/wdata; outputs the merged byteen/wdata.
- The FIFO pointers, count and hazard compare stay in store_buffer.

Test Plan:
- Reset, then one store (addr 0x100, byteen 0001, wdata 0x000000AB) with bus_ready=1:
  - next cycle bus_valid=1, bus_addr=0x100, bus_byteen=0001, bus_wdata=0x000000AB;
  - the cycle after that, empty=1.
- bus_ready=0; store 0x200/0011/0x00001234 then 0x202/1100/0x56780000:
  - a single entry results, byteen=1111, wdata=0x56781234, count=1.
- bus_ready=0; four stores to distinct words 0x0, 0x4, 0x8, 0xC:
  - in_ready=0 and a fifth store is not accepted;
  - raising bus_ready drains the four entries in order, one per cycle, and in_ready returns to 1 after the first drain.
- Buffer holds word 0x300; ld_check=1, ld_addr=0x302 gives ld_hazard=1; ld_addr=0x304 gives ld_hazard=0.
- count=1 at word 0x40 with bus_ready=1, and a store to 0x40 arrives in the same cycle:
  - it is not merged; it becomes a new entry, so bus shows 0x40 on two consecutive cycles.
- Pull reset_n low with three entries pending: outputs return to their reset values immediately (bus_valid=0, empty=1).
